stream_downsizer: RTL

- Sits directly downstream of the two-entry valid/ready FIFO stage and consumes its output stream.
- Takes one DATA_WIDTH word per handshake and emits it as RATIO = DATA_WIDTH/OUT_WIDTH consecutive OUT_WIDTH chunks, LSB chunk first.
- Valid/ready on both sides; a new word is accepted in the same cycle the last chunk of the previous word leaves, so streaming has no bubbles.

---
 rtl/stream_downsizer_if.sv | 29 ++
 rtl/stream_downsizer.sv | 46 ++++
 2 files changed

// File: rtl/stream_downsizer_if.sv
// stream_downsizer_if: word-in / chunk-out valid-ready bundle; o_last exists only with DOWNSIZER_LAST_EN
interface stream_downsizer_if #(
   parameter int DATA_WIDTH = 32,
   parameter int OUT_WIDTH  = 8
);
   logic                  i_valid;
   logic                  i_ready;
   logic [DATA_WIDTH-1:0] i_data;
   logic                  o_ready;
   logic                  o_valid;
   logic [OUT_WIDTH-1:0]  o_data;
`ifdef DOWNSIZER_LAST_EN
   logic                  o_last;
`endif
   modport slave (
`ifdef DOWNSIZER_LAST_EN
      output o_last,
`endif
      input  i_valid, i_data, o_ready,
      output i_ready, o_valid, o_data
   );
   modport master (
`ifdef DOWNSIZER_LAST_EN
      input  o_last,
`endif
      output i_valid, i_data, o_ready,
      input  i_ready, o_valid, o_data
   );
endinterface

// File: rtl/stream_downsizer.sv
// stream_downsizer: splits each DATA_WIDTH word into DATA_WIDTH/OUT_WIDTH chunks, LSB first; DOWNSIZER_LAST_EN adds o_last
module stream_downsizer #(
   parameter int DATA_WIDTH = 32,
   parameter int OUT_WIDTH  = 8
) (
   input logic clk,
   input logic n_rst,
   stream_downsizer_if.slave bus
);
   localparam int RATIO = DATA_WIDTH / OUT_WIDTH;
   localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
   if ((DATA_WIDTH % OUT_WIDTH) != 0 || RATIO < 2) begin : g_bad_ratio
      $error("stream_downsizer: DATA_WIDTH must be a multiple (>=2x) of OUT_WIDTH");
   end
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t                state, state_nx;
   logic [DATA_WIDTH-1:0] sreg, sreg_nx;
   logic [CW-1:0]         cnt, cnt_nx;
   logic                  last, accept, xfer;
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state <= IDLE;
         sreg  <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         sreg  <= sreg_nx;
         cnt   <= cnt_nx;
      end
   end
   // A new word wins over the shift so the last chunk and the next load share one edge
   always_comb begin
      last     = (state == SHIFT) && (cnt == CW'(RATIO - 1));
      xfer     = (state == SHIFT) && bus.o_ready;
      accept   = bus.i_valid && ((state == IDLE) || (last && bus.o_ready));
      state_nx = accept ? SHIFT : (xfer && last) ? IDLE : state;
      sreg_nx  = accept ? bus.i_data : xfer ? (sreg >> OUT_WIDTH) : sreg;
      cnt_nx   = (accept || (xfer && last)) ? '0 : xfer ? cnt + 1'b1 : cnt;
   end
   assign bus.i_ready = (state == IDLE) || (last && bus.o_ready);
   assign bus.o_valid = (state == SHIFT);
   assign bus.o_data  = sreg[OUT_WIDTH-1:0];
`ifdef DOWNSIZER_LAST_EN
   assign bus.o_last  = last;
`endif
endmodule
